// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and data (D).
// Ports: clk, rst (async, active-low); i_* fetch side, d_* load/store side,
// m_* memory side. Fixed D priority, I forced after STARVE_MAX lost rounds.
// Define ARB_TIMEOUT_EN to add the BUSY watchdog and sticky m_err output.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
`ifdef ARB_TIMEOUT_EN
  ,
  output logic              m_err
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX out of range 1..15");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC out of range 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY_I,
    S_BUSY_D,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [BE_W-1:0]   m_be_q, m_be_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC - 1);
  logic [7:0]        wd_q, wd_d;
  logic              m_err_q, m_err_d;
`endif

  logic grant_i;
  logic grant_d;

  // Fetch wins alone, or when it has lost STARVE_MAX rounds in a row.
  assign grant_i = i_req && (!d_req || (starve_q == STARVE_LIM));
  assign grant_d = d_req && !grant_i;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
    wd_d      = wd_q;
    m_err_d   = m_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef ARB_TIMEOUT_EN
        wd_d = '0;
`endif
        unique case (1'b1)
          grant_i: begin
            state_d   = S_BUSY_I;
            starve_d  = '0;
            m_req_d   = 1'b1;
            m_we_d    = 1'b0;
            m_be_d    = '1;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
          end
          grant_d: begin
            state_d   = S_BUSY_D;
            // Only reachable below the limit, so +1 never overshoots.
            if (i_req) starve_d = starve_q + 4'd1;
            m_req_d   = 1'b1;
            m_we_d    = d_we;
            m_be_d    = d_be;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
          end
          default: ;
        endcase
      end
      S_BUSY_I, S_BUSY_D: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          state_d = S_RESP;
          if (state_q == S_BUSY_I) begin
            i_rdata_d = m_rdata;
            i_ack_d   = 1'b1;
          end else begin
            d_rdata_d = m_rdata;
            d_ack_d   = 1'b1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_q == TO_LIM) begin
          m_req_d = 1'b0;
          m_err_d = 1'b1;
          state_d = S_RESP;
          if (state_q == S_BUSY_I) begin
            i_rdata_d = '1;
            i_ack_d   = 1'b1;
          end else begin
            d_rdata_d = '1;
            d_ack_d   = 1'b1;
          end
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      starve_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_q      <= '0;
      m_err_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef ARB_TIMEOUT_EN
      wd_q      <= wd_d;
      m_err_q   <= m_err_d;
`endif
    end
  end

  assign i_ack   = i_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_rdata = d_rdata_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
`ifdef ARB_TIMEOUT_EN
  assign m_err   = m_err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Random requesters and memory, grant order predicted from queue-level rules.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  typedef struct {
    bit          is_i;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req, i_ack, d_req, d_we, d_ack;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, m_be;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
`ifdef ARB_TIMEOUT_EN
  logic        m_err;
`endif

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
`ifdef ARB_TIMEOUT_EN
    , .m_err(m_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int bus_seen = 0;
  int last_cyc = -1;
  bit tput_en = 0;
  bit spur_en = 0;
  int lat_fix = 0;
  int mcnt = 0;

  txn_t iq[$], dq[$];
  txn_t exp_bus[$], exp_resp[$];
  logic [31:0] mmem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event, expected none", nm);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
      input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] r_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  // Reference: serve pending lists one at a time; D first unless fetch
  // has already lost SMAX contended rounds. Read data = word before write.
  task automatic predict(input txn_t il[$], input txn_t dl[$],
                         input int maxg);
    int g = 0;
    while ((il.size() > 0 || dl.size() > 0) && g < maxg) begin
      txn_t t;
      bit pick_i;
      if (il.size() > 0 && dl.size() > 0) begin
        if (mcnt == SMAX) pick_i = 1;
        else begin
          pick_i = 0;
          mcnt++;
        end
      end else begin
        pick_i = (il.size() > 0);
      end
      if (pick_i) begin
        t = il.pop_front();
        mcnt = 0;
      end else begin
        t = dl.pop_front();
      end
      t.rdata = m_rd(t.addr);
      if (t.we) mmem[t.addr] = merge(t.rdata, t.wdata, t.be);
      exp_bus.push_back(t);
      exp_resp.push_back(t);
      g++;
    end
  endtask

  function automatic txn_t mk_i(input logic [31:0] a);
    txn_t t;
    t.is_i = 1; t.we = 0; t.be = 4'hF;
    t.addr = a; t.wdata = '0; t.rdata = '0;
    return t;
  endfunction

  function automatic txn_t mk_d(input bit we, input logic [3:0] be,
      input logic [31:0] a, input logic [31:0] w);
    txn_t t;
    t.is_i = 0; t.we = we; t.be = be;
    t.addr = a; t.wdata = w; t.rdata = '0;
    return t;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h1000_0000 + 32'($urandom_range(15, 0)) * 4;
  endfunction

  function automatic txn_t rnd_d();
    return mk_d(1'($urandom_range(1, 0)), 4'($urandom_range(15, 1)),
                rnd_addr(), $urandom);
  endfunction

  task automatic issue(input txn_t il[$], input txn_t dl[$]);
    @(posedge clk);
    #2;
    predict(il, dl, 1000);
    foreach (il[k]) iq.push_back(il[k]);
    foreach (dl[k]) dq.push_back(dl[k]);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((iq.size() + dq.size() + exp_bus.size() + exp_resp.size()) > 0
           && k < budget) begin
      @(negedge clk);
      k++;
    end
    if ((iq.size() + dq.size() + exp_bus.size() + exp_resp.size()) > 0) begin
      chk("drain_timeout", 32'(exp_resp.size()), 32'd0);
      iq.delete(); dq.delete(); exp_bus.delete(); exp_resp.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic phase(input int ni, input int nd);
    txn_t il[$], dl[$];
    for (int k = 0; k < ni; k++) il.push_back(mk_i(rnd_addr()));
    for (int k = 0; k < nd; k++) dl.push_back(rnd_d());
    issue(il, dl);
    wait_done(20 * (ni + nd) + 50);
  endtask

  // Requesters: hold the head of their list until its ack is seen.
  initial begin : drv_i
    i_req = 0; i_addr = '0;
    forever begin
      @(negedge clk);
      if (rst && i_ack && iq.size() > 0) iq.delete(0);
      i_req  = (iq.size() > 0);
      i_addr = i_req ? iq[0].addr : '0;
    end
  end

  initial begin : drv_d
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst && d_ack && dq.size() > 0) dq.delete(0);
      d_req = (dq.size() > 0);
      if (d_req) begin
        d_we = dq[0].we; d_be = dq[0].be;
        d_addr = dq[0].addr; d_wdata = dq[0].wdata;
      end
    end
  end

  // Memory: acks lat cycles after m_req rises; stray acks while idle.
  initial begin : mem_model
    bit busy;
    int cnt, lat;
    busy = 0; cnt = 0; lat = 1;
    m_ack = 0; m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      m_ack = 0;
      if (!rst) begin
        busy = 0;
      end else if (m_req) begin
        if (!busy) begin
          busy = 1;
          cnt = 0;
          lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(3, 1));
        end else begin
          cnt++;
        end
        if (cnt == lat) begin
          m_ack = 1;
          m_rdata = r_rd(m_addr);
          if (m_we) rmem[m_addr] = merge(m_rdata, m_wdata, m_be);
        end
      end else begin
        busy = 0;
        if (spur_en && $urandom_range(3, 0) == 0) begin
          m_ack = 1;
          m_rdata = $urandom;
        end
      end
    end
  end

  initial begin : mon_bus
    bit prev;
    txn_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 0;
      end else begin
        if (m_req && !prev) begin
          bus_seen++;
          if (exp_bus.size() == 0) begin
            fail("bus_unexpected");
          end else begin
            e = exp_bus.pop_front();
            chk("m_addr", m_addr, e.addr);
            chk("m_we", 32'(m_we), 32'(e.we));
            chk("m_be", 32'(m_be), 32'(e.be));
            chk("m_wdata", m_wdata, e.wdata);
          end
        end
        prev = m_req;
      end
    end
  end

  initial begin : mon_resp
    logic [31:0] last_i, last_d;
    txn_t e;
    last_i = '0; last_d = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_i = '0; last_d = '0;
      end else if (i_ack || d_ack) begin
        chk("ack_overlap", 32'(i_ack & d_ack), 32'd0);
        if (exp_resp.size() == 0) begin
          fail("ack_unexpected");
        end else begin
          e = exp_resp.pop_front();
          chk("ack_owner_i", 32'(i_ack), 32'(e.is_i));
          if (e.is_i) begin
            chk("i_rdata", i_rdata, e.rdata);
            chk("d_rdata_hold", d_rdata, last_d);
          end else begin
            chk("d_rdata", d_rdata, e.rdata);
            chk("i_rdata_hold", i_rdata, last_i);
          end
        end
        last_i = i_rdata;
        last_d = d_rdata;
        if (tput_en && last_cyc >= 0) chk("ack_spacing", 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
      end
    end
  end

  task automatic reset_test();
    txn_t il[$], dl[$], none[$], d4;
    int b0, k;
    spur_en = 0;
    lat_fix = 1;
    il.push_back(mk_i(rnd_addr()));
    issue(il, none);
    wait_done(50);
    il.delete();
    lat_fix = 3;
    for (int n = 0; n < 3; n++) dl.push_back(rnd_d());
    d4 = mk_d(1, 4'b0101, 32'h1000_0040, 32'hA5A5_0F0F);
    dl.push_back(d4);
    il.push_back(mk_i(32'h1000_0044));
    @(posedge clk);
    #2;
    predict(il, dl, 3);
    exp_bus.push_back(d4);
    b0 = bus_seen;
    foreach (il[n]) iq.push_back(il[n]);
    foreach (dl[n]) dq.push_back(dl[n]);
    k = 0;
    while (bus_seen < b0 + 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_4th_grant", 32'(bus_seen - b0), 32'd4);
    @(posedge clk);
    #2;
    rst = 0;
    #1;
    chk("rst_async_m_req", 32'(m_req), 32'd0);
    chk("rst_no_ack", 32'(i_ack | d_ack), 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_no_ack", 32'(i_ack | d_ack), 32'd0);
    end
    mcnt = 0;
    @(posedge clk);
    #2;
    rst = 1;
    predict(iq, dq, 1000);
    wait_done(100);
  endtask

  initial begin : main
    txn_t il[$], dl[$], none[$];
    rst = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_be", 32'(m_be), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
`ifdef ARB_TIMEOUT_EN
    chk("rst_m_err", 32'(m_err), 32'd0);
`endif
    @(posedge clk);
    #2;
    rst = 1;

    mmem[32'h0040_0000] = 32'h3C01_0040;
    rmem[32'h0040_0000] = 32'h3C01_0040;
    lat_fix = 2;
    il.push_back(mk_i(32'h0040_0000));
    issue(il, none);
    wait_done(50);
    dl.push_back(mk_d(1, 4'b0011, 32'h1001_0004, 32'hDEAD_BEEF));
    issue(none, dl);
    wait_done(50);

    lat_fix = 0;
    phase(2, 10);

    spur_en = 1;
    repeat (20) phase($urandom_range(4, 0), $urandom_range(6, 0));

    spur_en = 0;
    lat_fix = 1;
    last_cyc = -1;
    tput_en = 1;
    phase(4, 4);
    tput_en = 0;

    reset_test();

`ifdef ARB_TIMEOUT_EN
    begin
      txn_t t, e;
      int hi;
      spur_en = 0;
      lat_fix = 100;
      t = mk_d(0, 4'hF, 32'h1000_0008, 32'h0);
      e = t;
      e.rdata = '1;
      @(posedge clk);
      #2;
      exp_bus.push_back(t);
      exp_resp.push_back(e);
      dq.push_back(t);
      hi = 0;
      for (int k = 0; k < 60 && !d_ack; k++) begin
        @(negedge clk);
        if (m_req) hi++;
      end
      chk("to_m_req_cycles", 32'(hi), 32'd10);
      chk("to_m_err_set", 32'(m_err), 32'd1);
      wait_done(50);
      lat_fix = 0;
      phase(1, 1);
      chk("to_m_err_sticky", 32'(m_err), 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL sim_watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
